// File: rtl/blocking_port_arbiter.sv
// blocking_port_arbiter: round-robin share of one blocking notify/sync output port among N requesters.
module blocking_port_arbiter #(
  parameter int N  = 2,
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N-1:0]                       req_notify,
  input  logic [N*W-1:0]                     req_data,
  output logic [N-1:0]                       req_sync,
  output logic [W-1:0]                       out_data,
  output logic                               out_notify,
  input  logic                               out_sync,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_id,
  output logic                               busy,
  output logic [CW-1:0]                      xfer_count
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;
  state_t         r_state, w_next;
  logic [GW-1:0]  r_rr_ptr, r_grant, w_pick, w_grant_inc;
  logic           w_found, r_notify;
  logic [W-1:0]   r_data;
  logic [N-1:0]   r_sync;
  logic [CW-1:0]  r_count;
  // Scan downward so the request closest above rr_ptr is the last (winning) assignment.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_notify[(int'(r_rr_ptr) + k) % N]) begin
        w_found = 1'b1;
        w_pick  = GW'((int'(r_rr_ptr) + k) % N);
      end
    end
  end
  assign w_grant_inc = (r_grant == GW'(N - 1)) ? '0 : r_grant + GW'(1);
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && w_found)  ? SEND :
             (r_state == SEND && out_sync) ? ACK  :
             (r_state == ACK)              ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_data   <= '0;
      r_notify <= 1'b0;
      r_sync   <= '0;
      r_count  <= '0;
    end else begin
      r_sync <= '0;
      if (r_state == IDLE && w_found) begin
        r_grant  <= w_pick;
        r_data   <= req_data[int'(w_pick)*W +: W];
        r_notify <= 1'b1;
      end
      if (r_state == SEND && out_sync) begin
        r_notify <= 1'b0;
        r_sync   <= N'(1) << r_grant;
        r_count  <= r_count + CW'(1);
        r_rr_ptr <= w_grant_inc;
      end
    end
  end
  assign req_sync   = r_sync;
  assign out_data   = r_data;
  assign out_notify = r_notify;
  assign grant_id   = r_grant;
  assign busy       = (r_state != IDLE);
  assign xfer_count = r_count;
endmodule

// File: doc/blocking_port_arbiter.md
Name: blocking_port_arbiter

Overview:
- Round-robin arbiter that shares one blocking output port (data plus notify/sync handshake) among N requesting sections or modules.
- Captures the winning requester's data, presents it on the shared port, and holds it until the consumer accepts.
- Acknowledges the winner with a one-cycle sync pulse, then re-arbitrates.
- Sits between generated section-based modules and a single downstream consumer port.

Parameters:
- N, 2, number of requesters (2..8).
- W, 32, data width in bits; data is treated as opaque, so signed and unsigned payloads pass unchanged.
- CW, 16, width of the transfer counter.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- req_notify  input  N  bit i high: requester i has valid data on its slice.
- req_data  input  N*W  requester i data in bits [i*W +: W].
- req_sync  output  N  one-cycle acknowledge to the requester whose data was accepted downstream.
- out_data  output  W  shared port data.
- out_notify  output  1  shared port valid; held until accepted.
- out_sync  input  1  consumer ready; transfer occurs in a cycle with out_notify && out_sync.
- grant_id  output  clog2(N) (min 1)  index of the current or last granted requester.
- busy  output  1  high in SEND and ACK.
- xfer_count  output  CW  completed transfers; wraps modulo 2^CW.

Behaviour:
- Reset (async, immediate): state=IDLE, out_notify=0, out_data=0, req_sync=0, grant_id=0, rr_ptr=0, xfer_count=0, busy=0.
- Reset mid-transfer aborts the transfer with no req_sync pulse; captured data is discarded.
- FSM states: IDLE, SEND, ACK.
- IDLE:
  - If any req_notify is high, pick the first set bit searching upward from rr_ptr with wrap-around.
  - On that edge: grant_id<=i, out_data<=req_data slice i, out_notify<=1, go to SEND.
  - If no request, stay in IDLE with outputs unchanged; out_data keeps its last value.
- SEND:
  - out_notify=1 and out_data stable.
  - req_notify and req_data changes are ignored.
  - If out_sync=1: out_notify<=0, req_sync[grant_id]<=1, xfer_count<=xfer_count+1, rr_ptr<=(grant_id+1) mod N, go to ACK.
  - If out_sync=0: hold, with no timeout.
- ACK:
  - req_sync is one-hot for exactly this cycle; no arbitration occurs.
  - Next edge: req_sync<=0, go to IDLE.
  - The requester must drop req_notify at that edge or present new data; IDLE samples the updated value.
- Latency:
  - out_notify rises 1 cycle after req_notify is sampled high in IDLE.
  - req_sync pulses 1 cycle after the out handshake.
  - Minimum 3 cycles per transfer (IDLE, SEND, ACK); back-to-back throughput is 1 transfer per 3 cycles when out_sync is held high.
- Fairness:
  - The winner becomes lowest priority next round.
  - A lone requester is regranted every round.
- out_sync while out_notify=0 (IDLE or ACK) is ignored.
- A requester dropping req_notify after grant does not cancel the transfer.
- xfer_count wraps 2^CW-1 -> 0 silently.
- busy = (state != IDLE).

Test Plan:
- Reset, then req_notify=01, req_data[0]=0xFFFFFFF9 (-7), out_sync=1 -> out_notify rises 1 cycle later with out_data=0xFFFFFFF9, grant_id=0; req_sync=01 for exactly one cycle after the handshake; xfer_count=1.
- Both requesters continuously asserted (data 13 and -7), out_sync=1 -> grants alternate 0,1,0,1 and out_data alternates 13, 0xFFFFFFF9; a new transfer starts every 3 cycles.
- Grant to 1 with out_sync=0 for 10 cycles -> out_notify and out_data stay stable, busy=1, no req_sync; raise out_sync -> exactly one req_sync[1] pulse.
- Assert rst while in SEND -> outputs return to reset values immediately; no req_sync; xfer_count=0; the next request is granted from rr_ptr=0.
- Force xfer_count to 0xFFFF via 65536 transfers (or CW=4 with 16 transfers) -> count wraps to 0.
- Change req_data[0] while in SEND -> out_data unchanged; req_notify drop in SEND -> transfer still completes and req_sync still pulses.
